double_pulse_checker: RTL and testbench
=======================================

Name: double_pulse_checker

Overview:
- Receive-side counterpart of the double-pulse generator: watches an asynchronous pulse line (K1 looped back, or the gate-drive feedback from the board).
- Measures first-pulse width, inter-pulse gap and second-pulse width in clk cycles.
- Compares each measurement against nominal ± tolerance and reports pass or error once per armed capture.
- Sits beside the generator in the PCB test top level and feeds results to the test sequencer.

Parameters:
- CNT_W, 16, width of all measurement counters and result ports.
- H1_NOM, 1200, nominal first-pulse width in clk cycles (30 us at 40 MHz).
- LOW_NOM, 800, nominal gap width in clk cycles (20 us).
- H2_NOM, 1200, nominal second-pulse width in clk cycles.
- TOL, 8, allowed ± deviation per field; must be < every NOM.
- TIMEOUT, 4000, maximum cycles in any waiting or measuring state; must be > max(NOM) + TOL.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  block enable; low aborts any capture.
- arm  in  1  single-cycle request to start a capture.
- pulse_in  in  1  asynchronous observed pulse line.
- busy  out  1  capture in progress.
- done  out  1  one-cycle strobe marking a completed capture (pass or fail).
- pass  out  1  last capture was within tolerance; held until next arm.
- err  out  3  error code of the last capture; held until next arm.
- w1  out  CNT_W  measured first-pulse width.
- gap  out  CNT_W  measured gap width.
- w2  out  CNT_W  measured second-pulse width.

Behaviour:
- Reset: state IDLE; busy, done and pass = 0; err = 0; w1, gap and w2 = 0; synchronizer flops = 0.
- Input conditioning: pulse_in passes through a 2-FF synchronizer (s1, s2) plus one history flop (s3). rise = s2 & ~s3; fall = ~s2 & s3.
- Measured width = number of rising clk edges at which pulse_in was sampled at that level.
- States: IDLE, WAIT_LOW, WAIT_H1, MEAS_H1, MEAS_LOW, MEAS_H2, DONE.
- IDLE: arm & enable -> clear pass, err, w1, gap and w2; set busy; counter = 0. Then go to WAIT_LOW if s2 = 1, otherwise WAIT_H1. arm is ignored outside IDLE.
- WAIT_LOW: fall -> WAIT_H1 with counter = 0.
- WAIT_H1: rise -> MEAS_H1 with counter = 1.
- MEAS_H1: s2 high -> counter + 1. fall -> latch w1 = counter, go to MEAS_LOW with counter = 1.
- MEAS_LOW: rise -> latch gap = counter, go to MEAS_H2 with counter = 1.
- MEAS_H2: fall -> latch w2 = counter, go to DONE.
- DONE (one cycle): done = 1, busy = 0.
  - pass = 1 iff every field satisfies NOM − TOL ≤ meas ≤ NOM + TOL.
  - Otherwise err is the first failing field in order: 2 = w1, 3 = gap, 4 = w2.
  - Return to IDLE.
- Timeout: in any WAIT or MEAS state, if counter reaches TIMEOUT, go to DONE with pass = 0.
  - err = 1 when timing out in WAIT_LOW or WAIT_H1.
  - err = 5 when timing out in any MEAS state.
  - The field being measured is latched as TIMEOUT; later fields stay 0.
- Counter increments saturate at all-ones and never wrap.
- Latency: done rises on the third clk edge after the first edge that samples pulse_in low at the end of pulse 2.
- enable low in any state: next state IDLE, busy = 0, done not asserted, err = 6, pass = 0. Measurements already latched are retained.
- rst has priority over everything, including in mid-capture.
- arm and timeout in the same cycle cannot occur, because arm is only sampled in IDLE.
- err codes: 0 OK, 1 no pulse, 2 H1 out of tolerance, 3 gap out of tolerance, 4 H2 out of tolerance, 5 stuck level, 6 aborted.

Decomposition:
- Package double_pulse_pkg holds:
  - the state encoding (3-bit enum);
  - the err code localparams;
  - the default nominal and tolerance constants, shared with the generator.
- One sub-module, pulse_edge_sync: 2-FF synchronizer plus history flop, outputs level, rise and fall. The checker's FSM, counter and compare logic stay in the top module.

Test Plan:
- Nominal: arm, then pulse_in high 1200 / low 800 / high 1200 cycles -> done once; pass = 1; err = 0; w1 = 1200, gap = 800, w2 = 1200; done 3 edges after the final fall.
- H1 = 1210, gap = 790, H2 = 1200 -> pass = 0; err = 2; w1 = 1210, gap = 790 reported.
- No pulse after arm -> done at counter = 4000 with err = 1; busy low the same cycle.
- pulse_in stuck high 5000 cycles after the first rise -> err = 5; w1 = 4000.
- pulse_in already high at arm -> block waits for low, then measures the next nominal double pulse -> pass = 1.
- enable dropped mid-MEAS_LOW -> IDLE, err = 6, no done, w1 retained. rst asserted mid-capture -> all outputs 0 next cycle. arm pulsed while busy -> ignored.

Source files
------------

// File: rtl/double_pulse_pkg.sv
// Shared definitions for the double-pulse generator/checker pair: state
// encoding, result codes and the default pulse timing.
package double_pulse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_LOW = 3'd1,
    ST_WAIT_H1  = 3'd2,
    ST_MEAS_H1  = 3'd3,
    ST_MEAS_LOW = 3'd4,
    ST_MEAS_H2  = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_NO_PULSE = 3'd1;
  localparam logic [2:0] ERR_H1       = 3'd2;
  localparam logic [2:0] ERR_GAP      = 3'd3;
  localparam logic [2:0] ERR_H2       = 3'd4;
  localparam logic [2:0] ERR_STUCK    = 3'd5;
  localparam logic [2:0] ERR_ABORT    = 3'd6;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_H1_NOM  = 1200;
  localparam int DEF_LOW_NOM = 800;
  localparam int DEF_H2_NOM  = 1200;
  localparam int DEF_TOL     = 8;
  localparam int DEF_TIMEOUT = 4000;

  // Written as meas + tol >= nom so the lower bound never underflows.
  function automatic logic in_tol(input int unsigned meas, input int unsigned nom,
                                  input int unsigned tol);
    return (meas + tol >= nom) && (meas <= nom + tol);
  endfunction

endpackage

// File: rtl/pulse_edge_sync.sv
// Two-flop synchronizer for the asynchronous pulse line plus a history flop
// for single-cycle rise/fall detection.
module pulse_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/double_pulse_checker.sv
// Measures first-pulse width, gap and second-pulse width of a looped-back
// double pulse and grades each against nominal +/- tolerance.
module double_pulse_checker
  import double_pulse_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int H1_NOM  = DEF_H1_NOM,
  parameter int LOW_NOM = DEF_LOW_NOM,
  parameter int H2_NOM  = DEF_H2_NOM,
  parameter int TOL     = DEF_TOL,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_arm,
  input  logic             i_pulse_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [2:0]       o_err,
  output logic [CNT_W-1:0] o_w1,
  output logic [CNT_W-1:0] o_gap,
  output logic [CNT_W-1:0] o_w2
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic w_level, w_rise, w_fall;

  pulse_edge_sync u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_pulse_in),
    .o_level(w_level),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CNT_W-1:0] r_w1, r_gap, r_w2, w_w1_nxt, w_gap_nxt, w_w2_nxt;
  logic [2:0]       r_err, w_err_nxt, r_pend, w_pend_nxt;
  logic             r_busy, w_busy_nxt, r_done, w_done_nxt, r_pass, w_pass_nxt;
  logic             w_tmo;

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_tmo     = (r_cnt >= TMO);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_w1    <= '0;
      r_gap   <= '0;
      r_w2    <= '0;
      r_err   <= ERR_OK;
      r_pend  <= ERR_OK;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_w1    <= w_w1_nxt;
      r_gap   <= w_gap_nxt;
      r_w2    <= w_w2_nxt;
      r_err   <= w_err_nxt;
      r_pend  <= w_pend_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  // r_pend carries a timeout code into DONE, where the final grade is made.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_w1_nxt    = r_w1;
    w_gap_nxt   = r_gap;
    w_w2_nxt    = r_w2;
    w_err_nxt   = r_err;
    w_pend_nxt  = r_pend;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    if (!i_enable) begin
      if (r_state != ST_IDLE) begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_err_nxt   = ERR_ABORT;
        w_pass_nxt  = 1'b0;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: if (i_arm) begin
          w_pass_nxt  = 1'b0;
          w_err_nxt   = ERR_OK;
          w_pend_nxt  = ERR_OK;
          w_w1_nxt    = '0;
          w_gap_nxt   = '0;
          w_w2_nxt    = '0;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_level ? ST_WAIT_LOW : ST_WAIT_H1;
        end
        ST_WAIT_LOW:
          if (w_tmo) begin
            w_pend_nxt = ERR_NO_PULSE; w_state_nxt = ST_DONE;
          end else if (w_fall) begin
            w_cnt_nxt = '0; w_state_nxt = ST_WAIT_H1;
          end else w_cnt_nxt = w_cnt_inc;
        ST_WAIT_H1:
          if (w_tmo) begin
            w_pend_nxt = ERR_NO_PULSE; w_state_nxt = ST_DONE;
          end else if (w_rise) begin
            w_cnt_nxt = CNT_W'(1); w_state_nxt = ST_MEAS_H1;
          end else w_cnt_nxt = w_cnt_inc;
        ST_MEAS_H1:
          if (w_tmo) begin
            w_w1_nxt = TMO; w_pend_nxt = ERR_STUCK; w_state_nxt = ST_DONE;
          end else if (w_fall) begin
            w_w1_nxt = r_cnt; w_cnt_nxt = CNT_W'(1); w_state_nxt = ST_MEAS_LOW;
          end else if (w_level) w_cnt_nxt = w_cnt_inc;
        ST_MEAS_LOW:
          if (w_tmo) begin
            w_gap_nxt = TMO; w_pend_nxt = ERR_STUCK; w_state_nxt = ST_DONE;
          end else if (w_rise) begin
            w_gap_nxt = r_cnt; w_cnt_nxt = CNT_W'(1); w_state_nxt = ST_MEAS_H2;
          end else w_cnt_nxt = w_cnt_inc;
        ST_MEAS_H2:
          if (w_tmo) begin
            w_w2_nxt = TMO; w_pend_nxt = ERR_STUCK; w_state_nxt = ST_DONE;
          end else if (w_fall) begin
            w_w2_nxt = r_cnt; w_state_nxt = ST_DONE;
          end else w_cnt_nxt = w_cnt_inc;
        ST_DONE: begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
          w_pass_nxt  = 1'b0;
          if (r_pend != ERR_OK)                        w_err_nxt = r_pend;
          else if (!in_tol(32'(r_w1), H1_NOM, TOL))    w_err_nxt = ERR_H1;
          else if (!in_tol(32'(r_gap), LOW_NOM, TOL))  w_err_nxt = ERR_GAP;
          else if (!in_tol(32'(r_w2), H2_NOM, TOL))    w_err_nxt = ERR_H2;
          else begin
            w_err_nxt  = ERR_OK;
            w_pass_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_pass = r_pass;
  assign o_err  = r_err;
  assign o_w1   = r_w1;
  assign o_gap  = r_gap;
  assign o_w2   = r_w2;

endmodule

// File: tb/tb_double_pulse_checker.sv
// Scenario bench for double_pulse_checker; per-edge sample streams are graded
// by a run-length reference model.
module tb_double_pulse_checker;

  localparam int W = 16, H1N = 1200, LN = 800, H2N = 1200, TL = 8, TMO = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b1, arm = 1'b0, pulse_in = 1'b0;
  logic busy, done, pass;
  logic [2:0] err;
  logic [W-1:0] w1, gap, w2;
  int n_chk = 0, n_fail = 0, n_done = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) n_done++;

  double_pulse_checker #(.CNT_W(W), .H1_NOM(H1N), .LOW_NOM(LN), .H2_NOM(H2N),
                         .TOL(TL), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_arm(arm), .i_pulse_in(pulse_in),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err(err),
    .o_w1(w1), .o_gap(gap), .o_w2(w2));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mkq(input int hi0, input int lo0, input int h1, input int g, input int h2,
                     output bit q[$]);
    q = {};
    repeat (hi0) q.push_back(1'b1);
    repeat (lo0) q.push_back(1'b0);
    repeat (h1)  q.push_back(1'b1);
    repeat (g)   q.push_back(1'b0);
    repeat (h2)  q.push_back(1'b1);
  endtask

  // Reference: skip any level present at arm, skip low, then take three runs.
  function automatic void model(input bit lvl0, input bit q[$], output bit e_pass,
                                output logic [2:0] e_err, output int e_w1,
                                output int e_gap, output int e_w2);
    int i;
    i = 0; e_w1 = 0; e_gap = 0; e_w2 = 0;
    if (lvl0) while (i < q.size() && q[i]) i++;
    while (i < q.size() && !q[i]) i++;
    while (i < q.size() && q[i])  begin e_w1++;  i++; end
    while (i < q.size() && !q[i]) begin e_gap++; i++; end
    while (i < q.size() && q[i])  begin e_w2++;  i++; end
    if (e_w1 < H1N - TL || e_w1 > H1N + TL)          e_err = 3'd2;
    else if (e_gap < LN - TL || e_gap > LN + TL)     e_err = 3'd3;
    else if (e_w2 < H2N - TL || e_w2 > H2N + TL)     e_err = 3'd4;
    else                                             e_err = 3'd0;
    e_pass = (e_err == 3'd0);
  endfunction

  // Drives one capture; lat = edges from last pulse-high sample until done seen.
  task automatic play(input bit lvl0, input bit q[$], input int rearm_at,
                      output int lat, output int ndone);
    int d0;
    pulse_in = lvl0;
    repeat (4) tick();
    d0 = n_done;
    arm = 1'b1; tick(); arm = 1'b0;
    foreach (q[i]) begin
      pulse_in = q[i];
      arm = (i == rearm_at);
      tick();
    end
    arm = 1'b0; pulse_in = 1'b0; lat = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done && lat == 0) lat = k;
    end
    ndone = n_done - d0;
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) tick();
    n_chk++; if ({busy, done, pass, err} !== 6'd0) begin n_fail++;
      $display("FAIL reset_flags got %b exp 000000", {busy, done, pass, err}); end
    n_chk++; if ({w1, gap, w2} !== '0) begin n_fail++;
      $display("FAIL reset_meas got %0d/%0d/%0d exp 0/0/0", w1, gap, w2); end
    rst = 1'b0; tick();
  endtask

  task automatic test_nominal();
    bit q[$]; int lat, nd;
    mkq(0, 20, 1200, 800, 1200, q);
    play(1'b0, q, -1, lat, nd);
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL nominal_latency got %0d exp 4", lat); end
    n_chk++; if (nd !== 1) begin n_fail++; $display("FAIL nominal_done_count got %0d exp 1", nd); end
    n_chk++; if ({pass, err, busy} !== 5'b1_000_0) begin n_fail++;
      $display("FAIL nominal_status got pass=%b err=%0d busy=%b exp 1/0/0", pass, err, busy); end
    n_chk++; if (w1 !== 16'd1200 || gap !== 16'd800 || w2 !== 16'd1200) begin n_fail++;
      $display("FAIL nominal_meas got %0d/%0d/%0d exp 1200/800/1200", w1, gap, w2); end
  endtask

  task automatic test_h1_err();
    bit q[$]; int lat, nd;
    mkq(0, 15, 1210, 790, 1200, q);
    play(1'b0, q, -1, lat, nd);
    n_chk++; if ({pass, err} !== 4'b0_010) begin n_fail++;
      $display("FAIL h1err_status got pass=%b err=%0d exp 0/2", pass, err); end
    n_chk++; if (w1 !== 16'd1210 || gap !== 16'd790 || w2 !== 16'd1200) begin n_fail++;
      $display("FAIL h1err_meas got %0d/%0d/%0d exp 1210/790/1200", w1, gap, w2); end
  endtask

  task automatic test_boundaries();
    int tbl[5][4] = '{'{1192, 792, 1208, 0}, '{1208, 808, 1192, 0}, '{1191, 800, 1200, 2},
                      '{1200, 809, 1200, 3}, '{1200, 800, 1209, 4}};
    bit q[$]; int lat, nd;
    foreach (tbl[i]) begin
      mkq(0, 10, tbl[i][0], tbl[i][1], tbl[i][2], q);
      play(1'b0, q, -1, lat, nd);
      n_chk++; if (err !== 3'(tbl[i][3]) || pass !== (tbl[i][3] == 0) || nd !== 1) begin n_fail++;
        $display("FAIL boundary_%0d got err=%0d pass=%b dones=%0d exp err=%0d", i, err, pass, nd, tbl[i][3]); end
    end
  endtask

  task automatic test_random();
    bit q[$]; int lat, nd, e_w1, e_gap, e_w2; bit lvl0, e_pass; logic [2:0] e_err;
    for (int it = 0; it < 6; it++) begin
      lvl0 = 1'($urandom_range(0, 1));
      mkq(lvl0 ? int'($urandom_range(3, 40)) : 0, $urandom_range(3, 40), $urandom_range(1188, 1212),
          $urandom_range(788, 812), $urandom_range(1188, 1212), q);
      model(lvl0, q, e_pass, e_err, e_w1, e_gap, e_w2);
      play(lvl0, q, -1, lat, nd);
      n_chk++; if ({pass, err, w1, gap, w2} !== {e_pass, e_err, W'(e_w1), W'(e_gap), W'(e_w2)} ||
                   lat !== 4 || nd !== 1) begin n_fail++;
        $display("FAIL random_%0d got p=%b e=%0d %0d/%0d/%0d lat=%0d n=%0d exp p=%b e=%0d %0d/%0d/%0d lat=4 n=1",
                 it, pass, err, w1, gap, w2, lat, nd, e_pass, e_err, e_w1, e_gap, e_w2); end
    end
  endtask

  task automatic test_no_pulse();
    int k;
    pulse_in = 1'b0; repeat (4) tick();
    arm = 1'b1; tick(); arm = 1'b0;
    k = 0;
    for (int c = 1; c <= TMO + 100 && k == 0; c++) begin tick(); if (done) k = c; end
    n_chk++; if (k !== TMO + 2) begin n_fail++; $display("FAIL nopulse_time got %0d exp %0d", k, TMO + 2); end
    n_chk++; if ({pass, err, busy} !== 5'b0_001_0 || {w1, gap, w2} !== '0) begin n_fail++;
      $display("FAIL nopulse_result got pass=%b err=%0d busy=%b w=%0d/%0d/%0d exp 0/1/0 0/0/0",
               pass, err, busy, w1, gap, w2); end
  endtask

  task automatic test_stuck_high();
    int k;
    pulse_in = 1'b0; repeat (4) tick();
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (10) tick();
    pulse_in = 1'b1; k = 0;
    for (int c = 1; c <= 5000; c++) begin tick(); if (done && k == 0) k = c; end
    n_chk++; if (k == 0 || {pass, err} !== 4'b0_101) begin n_fail++;
      $display("FAIL stuck_status got seen=%0d pass=%b err=%0d exp err=5", k, pass, err); end
    n_chk++; if (w1 !== 16'd4000 || gap !== 16'd0 || w2 !== 16'd0) begin n_fail++;
      $display("FAIL stuck_meas got %0d/%0d/%0d exp 4000/0/0", w1, gap, w2); end
    pulse_in = 1'b0; repeat (10) tick();
  endtask

  task automatic test_start_high();
    bit q[$]; int lat, nd;
    mkq(100, 30, 1200, 800, 1200, q);
    play(1'b1, q, -1, lat, nd);
    n_chk++; if ({pass, err} !== 4'b1_000 || w1 !== 16'd1200 || gap !== 16'd800 || nd !== 1) begin n_fail++;
      $display("FAIL starthigh got pass=%b err=%0d w=%0d/%0d/%0d n=%0d exp 1/0 1200/800/1200 n=1",
               pass, err, w1, gap, w2, nd); end
  endtask

  task automatic test_abort();
    int d0;
    pulse_in = 1'b0; repeat (4) tick();
    d0 = n_done;
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (10) tick();
    pulse_in = 1'b1; repeat (1200) tick();
    pulse_in = 1'b0; repeat (300) tick();
    enable = 1'b0; tick();
    n_chk++; if ({busy, pass, err} !== 5'b0_0_110) begin n_fail++;
      $display("FAIL abort_status got busy=%b pass=%b err=%0d exp 0/0/6", busy, pass, err); end
    n_chk++; if (w1 !== 16'd1200) begin n_fail++; $display("FAIL abort_w1 got %0d exp 1200", w1); end
    enable = 1'b1;
    repeat (500) tick();
    pulse_in = 1'b1; repeat (1200) tick();
    pulse_in = 1'b0; repeat (12) tick();
    n_chk++; if (n_done - d0 !== 0 || busy !== 1'b0 || err !== 3'd6) begin n_fail++;
      $display("FAIL abort_after got dones=%0d busy=%b err=%0d exp 0/0/6", n_done - d0, busy, err); end
  endtask

  task automatic test_arm_busy();
    bit q[$]; int lat, nd;
    mkq(0, 10, 1200, 800, 1200, q);
    play(1'b0, q, 10 + 1200 + 400, lat, nd);
    n_chk++; if ({pass, err} !== 4'b1_000 || w1 !== 16'd1200 || gap !== 16'd800 || w2 !== 16'd1200 ||
                 nd !== 1 || lat !== 4) begin n_fail++;
      $display("FAIL armbusy got pass=%b err=%0d w=%0d/%0d/%0d n=%0d lat=%0d exp 1/0 1200/800/1200 n=1 lat=4",
               pass, err, w1, gap, w2, nd, lat); end
  endtask

  task automatic test_rst_mid();
    pulse_in = 1'b0; repeat (4) tick();
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (10) tick();
    pulse_in = 1'b1; repeat (600) tick();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
    rst = 1'b1; tick();
    n_chk++; if ({busy, done, pass, err, w1, gap, w2} !== '0) begin n_fail++;
      $display("FAIL rstmid_outputs got b=%b d=%b p=%b e=%0d w=%0d/%0d/%0d exp all 0",
               busy, done, pass, err, w1, gap, w2); end
    rst = 1'b0; pulse_in = 1'b0; repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    // Results of a completed capture must clear on reset too.
    rst = 1'b1; tick();
    n_chk++; if ({pass, err, w1, gap, w2} !== '0) begin n_fail++;
      $display("FAIL rst_after_pass got p=%b e=%0d w=%0d/%0d/%0d exp all 0", pass, err, w1, gap, w2); end
    rst = 1'b0; tick();
    test_h1_err();
    test_boundaries();
    test_random();
    test_no_pulse();
    test_stuck_high();
    test_start_high();
    test_abort();
    test_arm_busy();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
